// File: rtl/iface_master_if.sv
// rtl/iface_master_if.sv - command/response and DUT register-port bundle for iface_master
interface iface_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [2:0] cmd_addr;
  logic       cmd_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_data;
  logic       rsp_err;
  logic [2:0] write_address;
  logic       write_data;
  logic       write_en;
  logic       write_rdy;
  logic [2:0] read_address;
  logic       read_en;
  logic       read_data;
  logic       read_rdy;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           write_rdy, read_data, read_rdy,
    output cmd_ready, rsp_valid, rsp_data, rsp_err,
           write_address, write_data, write_en, read_address, read_en
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           write_rdy, read_data, read_rdy,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err,
           write_address, write_data, write_en, read_address, read_en
  );
endinterface

// File: rtl/iface_master.sv
// rtl/iface_master.sv - single-command initiator for the dut register write/read ports
// Optional timeout abort path enabled by IFACE_MASTER_TIMEOUT_EN.
module iface_master #(
  parameter int TIMEOUT = 16,
  parameter int TW      = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  iface_master_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  state_t     r_state;
  logic       r_write;
  logic [2:0] r_addr;
  logic       r_wdata;
  logic       r_rsp_data;
  logic       w_issue;
  logic       w_xfer;

  assign w_issue = (r_state == S_ISSUE);
  assign w_xfer  = w_issue & (r_write ? bus.write_rdy : bus.read_rdy);

  // Enables follow ready combinationally so a strobe never sits on a low ready.
  assign bus.write_en      = w_issue &  r_write & bus.write_rdy;
  assign bus.read_en       = w_issue & ~r_write & bus.read_rdy;
  assign bus.cmd_ready     = (r_state == S_IDLE);
  assign bus.rsp_valid     = (r_state == S_RESP);
  assign bus.rsp_data      = r_rsp_data;
  assign bus.write_address = r_addr;
  assign bus.write_data    = r_wdata;
  assign bus.read_address  = r_addr;

`ifdef IFACE_MASTER_TIMEOUT_EN
  logic [TW-1:0] r_cnt;
  logic          r_rsp_err;

  assign bus.rsp_err = r_rsp_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_write    <= 1'b0;
      r_addr     <= 3'd0;
      r_wdata    <= 1'b0;
      r_rsp_data <= 1'b0;
      r_rsp_err  <= 1'b0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            r_write <= bus.cmd_write;
            r_addr  <= bus.cmd_addr;
            r_wdata <= bus.cmd_wdata;
            r_cnt   <= '0;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // A transfer in the limit cycle takes priority over the abort.
          if (w_xfer) begin
            r_rsp_data <= r_write ? 1'b0 : bus.read_data;
            r_rsp_err  <= 1'b0;
            r_state    <= S_RESP;
          end else if (r_cnt == TW'(TIMEOUT - 1)) begin
            r_rsp_data <= 1'b0;
            r_rsp_err  <= 1'b1;
            r_state    <= S_RESP;
          end else begin
            r_cnt <= r_cnt + TW'(1);
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
`else
  logic [TW-1:0] w_unused_timeout;

  assign w_unused_timeout = TW'(TIMEOUT);
  assign bus.rsp_err      = 1'b0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_write    <= 1'b0;
      r_addr     <= 3'd0;
      r_wdata    <= 1'b0;
      r_rsp_data <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            r_write <= bus.cmd_write;
            r_addr  <= bus.cmd_addr;
            r_wdata <= bus.cmd_wdata;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_xfer) begin
            r_rsp_data <= r_write ? 1'b0 : bus.read_data;
            r_state    <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_iface_master.sv
// tb/tb_iface_master.sv - scoreboard bench for iface_master (covers both IFACE_MASTER_TIMEOUT_EN builds)
module tb_iface_master;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [1:0] exp_q[$];   // {rsp_data, rsp_err}

  iface_master_if bus();

  iface_master #(.TIMEOUT(16)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: strobe legality every cycle, response scoreboard on each handshake.
  always @(negedge clk) begin
    chk("we_without_rdy", {7'd0, bus.write_en & ~bus.write_rdy}, 8'd0);
    chk("re_without_rdy", {7'd0, bus.read_en & ~bus.read_rdy}, 8'd0);
    if (bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 8'd1, 8'd0);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        chk("rsp_data", {7'd0, bus.rsp_data}, {7'd0, e[1]});
        chk("rsp_err", {7'd0, bus.rsp_err}, {7'd0, e[0]});
      end
    end
  end

  task automatic send_cmd(input logic w, input logic [2:0] a, input logic d);
    int n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    @(negedge clk);
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", {7'd0, bus.cmd_ready}, 8'd1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "bench timeout");
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 3'd0;
    bus.cmd_wdata = 1'b0;
    bus.rsp_ready = 1'b1;
    bus.write_rdy = 1'b0;
    bus.read_rdy  = 1'b0;
    bus.read_data = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", {7'd0, bus.cmd_ready}, 8'd1);
    chk("rst_rsp_valid", {7'd0, bus.rsp_valid}, 8'd0);
    chk("rst_rsp_err", {7'd0, bus.rsp_err}, 8'd0);
    chk("rst_waddr", {5'd0, bus.write_address}, 8'd0);
    chk("rst_raddr", {5'd0, bus.read_address}, 8'd0);
    reset_n = 1'b1;
    next_cycle();

    // Write, ready already high
    bus.write_rdy = 1'b1;
    exp_q.push_back(2'b00);
    send_cmd(1'b1, 3'd4, 1'b1);
    @(negedge clk);
    chk("wr_en_n1", {7'd0, bus.write_en}, 8'd1);
    chk("wr_addr", {5'd0, bus.write_address}, 8'd4);
    chk("wr_data", {7'd0, bus.write_data}, 8'd1);
    chk("wr_rspv_n1", {7'd0, bus.rsp_valid}, 8'd0);
    next_cycle();
    @(negedge clk);
    chk("wr_en_n2", {7'd0, bus.write_en}, 8'd0);
    chk("wr_rspv_n2", {7'd0, bus.rsp_valid}, 8'd1);
    next_cycle();

    // Read, ready already high
    bus.write_rdy = 1'b0;
    bus.read_rdy  = 1'b1;
    bus.read_data = 1'b1;
    exp_q.push_back(2'b10);
    send_cmd(1'b0, 3'd3, 1'b0);
    @(negedge clk);
    chk("rd_en_n1", {7'd0, bus.read_en}, 8'd1);
    chk("rd_addr", {5'd0, bus.read_address}, 8'd3);
    chk("rd_we_n1", {7'd0, bus.write_en}, 8'd0);
    next_cycle();
    bus.read_data = 1'b0;
    @(negedge clk);
    chk("rd_rspv_n2", {7'd0, bus.rsp_valid}, 8'd1);
    chk("rd_en_n2", {7'd0, bus.read_en}, 8'd0);
    next_cycle();

    // Write with backpressure, then held response
    bus.read_rdy  = 1'b0;
    bus.write_rdy = 1'b0;
    bus.rsp_ready = 1'b0;
    exp_q.push_back(2'b00);
    send_cmd(1'b1, 3'd6, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_we_low", {7'd0, bus.write_en}, 8'd0);
      chk("bp_rspv_low", {7'd0, bus.rsp_valid}, 8'd0);
      next_cycle();
    end
    bus.write_rdy = 1'b1;
    @(negedge clk);
    chk("bp_we_n6", {7'd0, bus.write_en}, 8'd1);
    next_cycle();
    bus.write_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_rspv", {7'd0, bus.rsp_valid}, 8'd1);
      chk("hold_data", {7'd0, bus.rsp_data}, 8'd0);
      chk("hold_err", {7'd0, bus.rsp_err}, 8'd0);
      chk("hold_cmd_ready", {7'd0, bus.cmd_ready}, 8'd0);
      chk("hold_we", {7'd0, bus.write_en}, 8'd0);
      next_cycle();
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("hold_release", {7'd0, bus.rsp_valid}, 8'd1);
    next_cycle();

`ifdef IFACE_MASTER_TIMEOUT_EN
    // Read timeout: ready stuck low
    exp_q.push_back(2'b01);
    send_cmd(1'b0, 3'd2, 1'b0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("to_re_low", {7'd0, bus.read_en}, 8'd0);
      chk("to_rspv_low", {7'd0, bus.rsp_valid}, 8'd0);
      next_cycle();
    end
    @(negedge clk);
    chk("to_rspv_n17", {7'd0, bus.rsp_valid}, 8'd1);
    chk("to_err_n17", {7'd0, bus.rsp_err}, 8'd1);
    next_cycle();

    // Ready rises in the limit cycle: transfer wins
    exp_q.push_back(2'b10);
    send_cmd(1'b0, 3'd2, 1'b0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("lim_re_low", {7'd0, bus.read_en}, 8'd0);
      next_cycle();
    end
    bus.read_rdy  = 1'b1;
    bus.read_data = 1'b1;
    @(negedge clk);
    chk("lim_re_n16", {7'd0, bus.read_en}, 8'd1);
    next_cycle();
    bus.read_rdy  = 1'b0;
    bus.read_data = 1'b0;
    @(negedge clk);
    chk("lim_rspv_n17", {7'd0, bus.rsp_valid}, 8'd1);
    chk("lim_err_n17", {7'd0, bus.rsp_err}, 8'd0);
    next_cycle();
`else
    // No timeout: indefinite wait on read_rdy
    begin
      int n_early = 0;
      exp_q.push_back(2'b10);
      send_cmd(1'b0, 3'd1, 1'b0);
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (bus.read_en || bus.rsp_valid) n_early++;
        next_cycle();
      end
      chk("wait_no_early", n_early[7:0], 8'd0);
      bus.read_rdy  = 1'b1;
      bus.read_data = 1'b1;
      @(negedge clk);
      chk("wait_re_pulse", {7'd0, bus.read_en}, 8'd1);
      next_cycle();
      @(negedge clk);
      chk("wait_re_single", {7'd0, bus.read_en}, 8'd0);
      chk("wait_rspv", {7'd0, bus.rsp_valid}, 8'd1);
      chk("wait_err", {7'd0, bus.rsp_err}, 8'd0);
      next_cycle();
      bus.read_rdy  = 1'b0;
      bus.read_data = 1'b0;
    end
`endif

    // Reset mid-ISSUE drops the command and kills the strobe at once
    bus.write_rdy = 1'b0;
    send_cmd(1'b1, 3'd5, 1'b1);
    next_cycle();
    @(negedge clk);
    bus.write_rdy = 1'b1;
    #1;
    chk("rst_pre_we", {7'd0, bus.write_en}, 8'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_async_we", {7'd0, bus.write_en}, 8'd0);
    bus.write_rdy = 1'b0;
    next_cycle();
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_post_cmd_ready", {7'd0, bus.cmd_ready}, 8'd1);
    chk("rst_post_rspv", {7'd0, bus.rsp_valid}, 8'd0);
    chk("rst_post_waddr", {5'd0, bus.write_address}, 8'd0);
    repeat (5) next_cycle();
    @(negedge clk);
    chk("rst_no_stale", {7'd0, bus.rsp_valid}, 8'd0);
    chk("scoreboard_empty", exp_q.size() > 0 ? 8'd1 : 8'd0, 8'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
